node_operand_feeder: RTL and testbench

- Upstream stage of node_calculator. Holds one node's input vector and weight vector in local register buffers.
- On `start`, clears the accumulator, then streams (value, weight) pairs one per clock into the calculator's value/weight inputs.
- Waits out the calculator latency, then captures the accumulated result for the layer controller.
- Drives zero operands whenever it is not streaming, so the free-running accumulator never picks up stray products.

---
 rtl/nn_pkg.sv | 19 +
 rtl/node_operand_buffer.sv | 48 ++++
 rtl/node_operand_feeder.sv | 172 +++++++++++++++++
 tb/tb_node_operand_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-node datapath.
//   DATA_W_DEF / FRAC_BITS_DEF : default operand format (Q11.4 in 16 bits)
//   FX_ONE                     : fixed-point 1.0 for the default format
//   feeder_state_t             : operand feeder sequencing states
package nn_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned FRAC_BITS_DEF = 4;
  localparam int unsigned FX_ONE        = 1 << FRAC_BITS_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/node_operand_buffer.sv
// Dual register file holding one node's input values and weights.
//   i_clk               : rising-edge clock (contents are never reset)
//   i_we                : write both files at i_waddr
//   i_waddr             : write index; indices >= N_INPUTS are dropped
//   i_wvalue, i_wweight : write data
//   i_raddr             : asynchronous read index (out of range reads 0)
//   o_rvalue, o_rweight : read data
module node_operand_buffer
  import nn_pkg::*;
#(
  parameter int unsigned N_INPUTS = 10,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [7:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wvalue,
  input  logic [DATA_W-1:0] i_wweight,
  input  logic [7:0]        i_raddr,
  output logic [DATA_W-1:0] o_rvalue,
  output logic [DATA_W-1:0] o_rweight
);

  logic [DATA_W-1:0] r_vbuf [N_INPUTS];
  logic [DATA_W-1:0] r_wbuf [N_INPUTS];

  // Full 8-bit address compare per entry, so out-of-range indices match nothing.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (i_we && (i_waddr == 8'(k))) begin
        r_vbuf[k] <= i_wvalue;
        r_wbuf[k] <= i_wweight;
      end
    end
  end

  always_comb begin
    o_rvalue  = '0;
    o_rweight = '0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (i_raddr == 8'(k)) begin
        o_rvalue  = r_vbuf[k];
        o_rweight = r_wbuf[k];
      end
    end
  end

endmodule

// File: rtl/node_operand_feeder.sv
// Operand feeder for node_calculator: buffers one node's value/weight pairs,
// clears the accumulator, streams the pairs, waits out the calculator
// latency and captures the result.
//   clk, reset (async, active low)
//   load_en/load_addr/load_value/load_weight : buffer write port (IDLE only)
//   start        : begin a node computation
//   busy         : computation in progress (through the done cycle)
//   value/weight : operands to the calculator, zero unless streaming
//   acc_clear    : accumulator clear, one cycle before the first pair
//   pair_valid, last_pair : stream qualifiers
//   calc_result  : calculator output, result/done : captured node result
// Build option: NODE_FEEDER_RELU_EN clamps negative results to zero.
module node_operand_feeder
  import nn_pkg::*;
#(
  parameter int unsigned N_INPUTS     = 10,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF,
  parameter int unsigned CALC_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [7:0]        load_addr,
  input  logic [DATA_W-1:0] load_value,
  input  logic [DATA_W-1:0] load_weight,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] weight,
  output logic              acc_clear,
  output logic              pair_valid,
  output logic              last_pair,
  input  logic [DATA_W-1:0] calc_result,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  if (N_INPUTS < 2 || N_INPUTS > 255) begin : g_bad_n_inputs
    $error("node_operand_feeder: N_INPUTS must be 2..255");
  end
  if (CALC_LATENCY < 1 || CALC_LATENCY > 7) begin : g_bad_latency
    $error("node_operand_feeder: CALC_LATENCY must be 1..7");
  end
  // The feeder never rescales; only reject formats with no integer bit.
  if (FRAC_BITS >= DATA_W) begin : g_bad_frac_bits
    $error("node_operand_feeder: FRAC_BITS must be below DATA_W");
  end

  localparam logic [7:0] LAST_IDX   = 8'(N_INPUTS - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(CALC_LATENCY - 1);

  feeder_state_t     r_state, w_state_nx;
  logic [7:0]        r_idx, w_idx_nx;
  logic [2:0]        r_drain, w_drain_nx;

  logic              r_busy, r_acc_clear, r_pair_valid, r_last_pair, r_done;
  logic [DATA_W-1:0] r_value, r_weight, r_result;
  logic              w_busy_nx, w_acc_clear_nx, w_pair_valid_nx, w_last_pair_nx, w_done_nx;
  logic [DATA_W-1:0] w_value_nx, w_weight_nx, w_result_nx;

  logic [DATA_W-1:0] w_rvalue, w_rweight, w_capture_val;
  logic              w_buf_we;

  assign w_buf_we = load_en && (r_state == IDLE);

  // Read address is the next index so the registered operands line up
  // with the registered pair_valid / last_pair.
  node_operand_buffer #(
    .N_INPUTS (N_INPUTS),
    .DATA_W   (DATA_W)
  ) u_buf (
    .i_clk     (clk),
    .i_we      (w_buf_we),
    .i_waddr   (load_addr),
    .i_wvalue  (load_value),
    .i_wweight (load_weight),
    .i_raddr   (w_idx_nx),
    .o_rvalue  (w_rvalue),
    .o_rweight (w_rweight)
  );

`ifdef NODE_FEEDER_RELU_EN
  assign w_capture_val = calc_result[DATA_W-1] ? '0 : calc_result;
`else
  assign w_capture_val = calc_result;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_drain      <= '0;
      r_busy       <= 1'b0;
      r_acc_clear  <= 1'b0;
      r_pair_valid <= 1'b0;
      r_last_pair  <= 1'b0;
      r_done       <= 1'b0;
      r_value      <= '0;
      r_weight     <= '0;
      r_result     <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_drain      <= w_drain_nx;
      r_busy       <= w_busy_nx;
      r_acc_clear  <= w_acc_clear_nx;
      r_pair_valid <= w_pair_valid_nx;
      r_last_pair  <= w_last_pair_nx;
      r_done       <= w_done_nx;
      r_value      <= w_value_nx;
      r_weight     <= w_weight_nx;
      r_result     <= w_result_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_drain_nx = r_drain;
    unique case (r_state)
      IDLE:    if (start) w_state_nx = CLEAR;
      CLEAR: begin
        w_state_nx = STREAM;
        w_idx_nx   = '0;
      end
      STREAM: begin
        if (r_idx == LAST_IDX) begin
          w_state_nx = DRAIN;
          w_drain_nx = '0;
        end else begin
          w_idx_nx = r_idx + 8'd1;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST) w_state_nx = CAPTURE;
        else                       w_drain_nx = r_drain + 3'd1;
      end
      CAPTURE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_busy_nx       = (w_state_nx != IDLE);
    w_acc_clear_nx  = (w_state_nx == CLEAR);
    w_pair_valid_nx = (w_state_nx == STREAM);
    w_last_pair_nx  = (w_state_nx == STREAM) && (w_idx_nx == LAST_IDX);
    w_done_nx       = (w_state_nx == CAPTURE);
    w_value_nx      = '0;
    w_weight_nx     = '0;
    w_result_nx     = r_result;
    if (w_state_nx == STREAM) begin
      w_value_nx  = w_rvalue;
      w_weight_nx = w_rweight;
    end
    if (w_state_nx == CAPTURE) w_result_nx = w_capture_val;
  end

  assign busy       = r_busy;
  assign value      = r_value;
  assign weight     = r_weight;
  assign acc_clear  = r_acc_clear;
  assign pair_valid = r_pair_valid;
  assign last_pair  = r_last_pair;
  assign result     = r_result;
  assign done       = r_done;

endmodule

// File: tb/tb_node_operand_feeder.sv
// Bench for node_operand_feeder: two instances (calculator latency 1 and 3)
// share stimulus; each has its own calculator model, buffer model, cycle
// model of the expected outputs and a result scoreboard.
module tb_node_operand_feeder;

  localparam int unsigned N  = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned FB = 4;
  localparam int unsigned L0 = 1;
  localparam int unsigned L1 = 3;

  logic          clk;
  logic          reset;
  logic          load_en;
  logic [7:0]    load_addr;
  logic [DW-1:0] load_value, load_weight;
  logic          start;

  logic          busy_o      [2];
  logic [DW-1:0] value_o     [2];
  logic [DW-1:0] weight_o    [2];
  logic          acc_clear_o [2];
  logic          pair_valid_o[2];
  logic          last_pair_o [2];
  logic [DW-1:0] calc_res    [2];
  logic [DW-1:0] result_o    [2];
  logic          done_o      [2];

  int checks = 0;
  int errors = 0;

  node_operand_feeder #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(FB), .CALC_LATENCY(L0)) u_dut0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_value(load_value), .load_weight(load_weight), .start(start),
    .busy(busy_o[0]), .value(value_o[0]), .weight(weight_o[0]),
    .acc_clear(acc_clear_o[0]), .pair_valid(pair_valid_o[0]), .last_pair(last_pair_o[0]),
    .calc_result(calc_res[0]), .result(result_o[0]), .done(done_o[0])
  );

  node_operand_feeder #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(FB), .CALC_LATENCY(L1)) u_dut1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_value(load_value), .load_weight(load_weight), .start(start),
    .busy(busy_o[1]), .value(value_o[1]), .weight(weight_o[1]),
    .acc_clear(acc_clear_o[1]), .pair_valid(pair_valid_o[1]), .last_pair(last_pair_o[1]),
    .calc_result(calc_res[1]), .result(result_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Q.FB product, kept in 32 bits.
  function automatic logic signed [31:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[DW-1]}}, a};
    sb = {{16{b[DW-1]}}, b};
    return (sa * sb) >>> FB;
  endfunction

  // ---------------- calculator models ----------------
  logic signed [31:0] acc0 = 0;
  logic signed [31:0] acc1 = 0;
  logic [DW-1:0]      dly1a = '0, dly1b = '0;

  always @(posedge clk) begin
    if (acc_clear_o[0])       acc0 <= 0;
    else if (pair_valid_o[0]) acc0 <= acc0 + prod(value_o[0], weight_o[0]);
    if (acc_clear_o[1])       acc1 <= 0;
    else if (pair_valid_o[1]) acc1 <= acc1 + prod(value_o[1], weight_o[1]);
    dly1a <= acc1[DW-1:0];
    dly1b <= dly1a;
  end
  assign calc_res[0] = acc0[DW-1:0];
  assign calc_res[1] = dly1b;

  // ---------------- reference model ----------------
  logic [DW-1:0] mv [2][N];
  logic [DW-1:0] mw [2][N];
  int            tstart [2];
  logic [DW-1:0] exp_res [2];
  logic [DW-1:0] sbq0 [$];
  logic [DW-1:0] sbq1 [$];

  function automatic int last_k(input int d);
    return 1 + N + ((d == 0) ? L0 : L1);
  endfunction

  function automatic bit model_idle(input int d, input int e);
    return (tstart[d] < 0) || ((e - tstart[d]) > last_k(d));
  endfunction

  function automatic logic [DW-1:0] model_result(input int d);
    logic signed [31:0] s;
    logic [DW-1:0] r;
    s = 0;
    for (int i = 0; i < N; i++) s += prod(mv[d][i], mw[d][i]);
    r = s[DW-1:0];
`ifdef NODE_FEEDER_RELU_EN
    if (r[DW-1]) r = '0;
`endif
    return r;
  endfunction

  // Called #1 after a rising edge; occupies exactly one cycle.
  task automatic drive_cycle(input bit ld, input logic [7:0] a, input logic [DW-1:0] v,
                             input logic [DW-1:0] w, input bit st);
    int e;
    load_en = ld; load_addr = a; load_value = v; load_weight = w; start = st;
    e = cyc;
    for (int d = 0; d < 2; d++) begin
      if (reset && model_idle(d, e)) begin
        if (ld && (a < N)) begin
          mv[d][a] = v;
          mw[d][a] = w;
        end
        if (st) begin
          tstart[d] = e + 1;
          if (d == 0) sbq0.push_back(model_result(0));
          else        sbq1.push_back(model_result(1));
        end
      end
    end
    @(posedge clk); #1;
    load_en = 1'b0; start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tstart = '{-1, -1};
    exp_res = '{'0, '0};
    sbq0.delete();
    sbq1.delete();
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  // ---------------- per-cycle checker ----------------
  int            ck_k, ck_lk;
  bit            ck_act, ck_pv;
  logic [DW-1:0] ck_v, ck_w, ck_pop;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ck_lk  = last_k(d);
      ck_k   = cyc - tstart[d];
      ck_act = reset && (tstart[d] >= 0) && (ck_k >= 0) && (ck_k <= ck_lk);
      ck_pv  = ck_act && (ck_k >= 1) && (ck_k <= N);
      ck_v   = '0;
      ck_w   = '0;
      if (ck_pv) begin
        ck_v = mv[d][ck_k-1];
        ck_w = mw[d][ck_k-1];
      end
      check_eq($sformatf("busy%0d", d),       busy_o[d],       ck_act);
      check_eq($sformatf("acc_clear%0d", d),  acc_clear_o[d],  ck_act && (ck_k == 0));
      check_eq($sformatf("pair_valid%0d", d), pair_valid_o[d], ck_pv);
      check_eq($sformatf("last_pair%0d", d),  last_pair_o[d],  ck_pv && (ck_k == N));
      check_eq($sformatf("value%0d", d),      value_o[d],      ck_v);
      check_eq($sformatf("weight%0d", d),     weight_o[d],     ck_w);
      check_eq($sformatf("done%0d", d),       done_o[d],       ck_act && (ck_k == ck_lk));
      if (done_o[d] === 1'b1) begin
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
          check_eq($sformatf("unexpected_done%0d", d), done_o[d], 1'b0);
        end else begin
          ck_pop = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
          exp_res[d] = ck_pop;
          check_eq($sformatf("result%0d", d), result_o[d], ck_pop);
        end
      end else begin
        check_eq($sformatf("result_hold%0d", d), result_o[d], exp_res[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] tv [N];
  logic [DW-1:0] tw [N];
  logic [DW-1:0] relu_exp;

  initial begin
    tv = '{16'h0014, 16'h0028, 16'h0028, 16'h0020, 16'h0030,
           16'h0020, 16'h0014, 16'h0038, 16'h0048, 16'h0020};
    tw = '{16'h0018, 16'h0018, 16'h0050, 16'h0020, 16'h0050,
           16'h0030, 16'h0038, 16'h0050, 16'h0040, 16'h0030};
    reset = 1'b0; load_en = 1'b0; load_addr = '0;
    load_value = '0; load_weight = '0; start = 1'b0;
    tstart = '{-1, -1};
    exp_res = '{'0, '0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick(2);

    // Main table plus an out-of-range write that must be dropped.
    for (int i = 0; i < N; i++) drive_cycle(1'b1, 8'(i), tv[i], tw[i], 1'b0);
    drive_cycle(1'b1, 8'd10, 16'h7777, 16'h7777, 1'b0);
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(20);
    check_eq("result_89_lat1", result_o[0], 16'h0590);
    check_eq("result_89_lat3", result_o[1], 16'h0590);

    // Load and start while streaming are both ignored.
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(4);
    drive_cycle(1'b1, 8'd3, 16'h7FFF, 16'h7FFF, 1'b1);
    tick(20);
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(20);

    // Start in the cycle right after done (latency-1 instance).
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(L0 + N + 2);
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(20);

    // Write and start in the same cycle: new entry is streamed.
    drive_cycle(1'b1, 8'd5, 16'h0010, 16'h0030, 1'b1);
    tick(20);

    // Reset while pair 4 is on the operands, then replay.
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(5);
    reset_pulse();
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(20);

    // Negative result: -8.0 * 1.0.
    for (int i = 0; i < N; i++)
      drive_cycle(1'b1, 8'(i), (i == 0) ? 16'hFF80 : 16'h0000, (i == 0) ? 16'h0010 : 16'h0000, 1'b0);
    drive_cycle(1'b0, 8'd0, '0, '0, 1'b1);
    tick(20);
`ifdef NODE_FEEDER_RELU_EN
    relu_exp = 16'h0000;
`else
    relu_exp = 16'hFF80;
`endif
    check_eq("result_negative", result_o[0], relu_exp);

    check_eq("scoreboard_empty0", sbq0.size(), 0);
    check_eq("scoreboard_empty1", sbq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
